// File: rtl/count_chk_pkg.sv
// Shared types and widths for the counter-stream checker.
package count_chk_pkg;
  typedef enum logic [1:0] {UNLOCKED, LOCKED, FAULT} chk_state_t;
  localparam int ERR_CNT_W    = 8;
  localparam int SAMPLE_CNT_W = 16;
  localparam int CONSEC_W     = 4;
endpackage

// File: rtl/count_stream_checker_sat_counter.sv
// Up-counter with synchronous clear and optional saturation at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         sat_en_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && !(sat_en_i && (&cnt_q)))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/count_stream_checker.sv
// Checks that a sampled counter stream advances by exactly +1 (mod 2^WIDTH),
// counting mismatches and latching a fault after ERR_LIMIT consecutive misses.
module count_stream_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int THRESH    = 5,
  parameter int ERR_LIMIT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    locked,
  output logic                    above_thresh,
  output logic                    seq_err,
  output logic [ERR_CNT_W-1:0]    err_count,
  output logic [SAMPLE_CNT_W-1:0] sample_count,
  output logic                    fault
);
  chk_state_t              state_q, state_d;
  logic [WIDTH-1:0]        expected_q, expected_d;
  logic [SAMPLE_CNT_W-1:0] sample_q, sample_d;
  logic                    above_q, above_d;
  logic                    seq_err_q, seq_err_d;
  logic [CONSEC_W-1:0]     consec;

  logic accept, match, mismatch, consec_clr;

  // A clear on the same cycle as in_valid drops the sample; FAULT ignores input.
  assign accept     = in_valid && !clear && (state_q != FAULT);
  assign match      = (in_data == expected_q);
  assign mismatch   = accept && (state_q == LOCKED) && !match;
  assign consec_clr = clear || (accept && (state_q == LOCKED) && match);

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    sample_d   = sample_q;
    above_d    = above_q;
    seq_err_d  = mismatch;
    if (accept) begin
      expected_d = in_data + 1'b1;
      sample_d   = sample_q + 1'b1;
      above_d    = 32'(in_data) > 32'(THRESH);
    end
    case (state_q)
      UNLOCKED: if (accept) state_d = LOCKED;
      LOCKED:   if (mismatch && consec == CONSEC_W'(ERR_LIMIT - 1)) state_d = FAULT;
      FAULT:    state_d = FAULT;
      default:  state_d = UNLOCKED;
    endcase
    if (clear) begin
      state_d    = UNLOCKED;
      expected_d = '0;
      sample_d   = '0;
      above_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNLOCKED;
      expected_q <= '0;
      sample_q   <= '0;
      above_q    <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      sample_q   <= sample_d;
      above_q    <= above_d;
      seq_err_q  <= seq_err_d;
    end
  end

  sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clear),
    .inc_i    (mismatch),
    .sat_en_i (1'b1),
    .cnt_o    (err_count)
  );

  sat_counter #(.W(CONSEC_W)) u_consec_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (consec_clr),
    .inc_i    (mismatch),
    .sat_en_i (1'b1),
    .cnt_o    (consec)
  );

  assign locked       = (state_q == LOCKED);
  assign fault        = (state_q == FAULT);
  assign above_thresh = above_q;
  assign seq_err      = seq_err_q;
  assign sample_count = sample_q;
endmodule

// File: doc/count_stream_checker.md
Name: count_stream_checker

Overview:
- Receiver side of the free-running counter stream: an upstream generator drives an unsigned WIDTH-bit value that starts at 0 and increments by 1 per update.
- This block samples that value on a valid strobe and checks that every update is exactly previous+1, modulo 2^WIDTH.
- Reports sequence errors, a sticky fault, and a registered "value above threshold" flag, using an unsigned integer compare.
- Sits beside the generator in the test/top level and replaces ad-hoc behavioural threshold checks with synthesizable logic.

Parameters:
- WIDTH, 8, bit width of the monitored counter value.
- THRESH, 5, unsigned threshold; above_thresh is asserted when the value is strictly greater than THRESH.
- ERR_LIMIT, 3, number of consecutive sequence errors that forces FAULT (legal range 1..15).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous soft clear; returns the block to UNLOCKED and zeroes the counters.
- in_valid  input  1  in_data carries a new counter update this cycle.
- in_data  input  WIDTH  counter value from the generator.
- locked  output  1  high while in LOCKED.
- above_thresh  output  1  registered; the last accepted value is greater than THRESH.
- seq_err  output  1  one-cycle pulse on each sequence mismatch.
- err_count  output  8  total mismatches, saturating at 255.
- sample_count  output  16  accepted samples, wrapping at 2^16.
- fault  output  1  sticky; high in the FAULT state.

Behaviour:
- Reset: every output is 0; the FSM enters UNLOCKED; expected and the consecutive-error counter are 0. A reset mid-stream discards all history.
- clear: same effect as rst. It has no effect on cycles where rst is also asserted. If clear and in_valid are asserted together, the sample is dropped.
- Every output is registered. A sample on cycle N is reflected on cycle N+1.
- FSM states: UNLOCKED, LOCKED, FAULT.
- UNLOCKED with in_valid:
  - expected <= in_data+1, computed at WIDTH bits with wrap.
  - Go to LOCKED; no error check is made.
- LOCKED with in_valid and in_data==expected:
  - expected <= in_data+1.
  - Consecutive-error counter <= 0.
- LOCKED with in_valid and in_data!=expected:
  - seq_err pulses.
  - err_count increments, saturating at 255.
  - Consecutive-error counter increments.
  - Resync: expected <= in_data+1.
  - If the consecutive count reaches ERR_LIMIT, go to FAULT and set fault=1.
- FAULT: in_valid is ignored. sample_count, err_count and above_thresh freeze. Exit is only by clear or rst, both to UNLOCKED.
- In UNLOCKED and LOCKED, every accepted sample increments sample_count and updates above_thresh <= (in_data > THRESH), compared unsigned and zero-extended to 32 bits.
- Wrap-around: in_data = 2^WIDTH-1 followed by 0 is legal and raises no error.
- A cycle without in_valid changes only seq_err, which returns to 0.

Decomposition:
- Shared package count_chk_pkg holds:
  - typedef enum logic [1:0] {UNLOCKED, LOCKED, FAULT} chk_state_t;
  - localparam ERR_CNT_W = 8;
  - localparam SAMPLE_CNT_W = 16.
- One sub-module, sat_counter (parameterised width, increment, clear, saturate enable), used for err_count and the consecutive-error counter.
- sample_count is a plain wrapping counter built inline.

Test Plan:
- Reset then stream 0..10, one sample every 10 cycles:
  - locked=1 from the cycle after sample 0.
  - seq_err never asserts; err_count=0; sample_count=11.
  - above_thresh goes 0→1 the cycle after sample 6.
- Stream 253,254,255,0,1:
  - No seq_err across the 255→0 wrap.
  - above_thresh=1 through 255; 0 after sample 0.
- Stream 0,1,2,7,8:
  - seq_err pulses exactly once, the cycle after sample 7; err_count=1.
  - Resync holds, so 8 produces no error.
- Stream 0,5,9,20 with ERR_LIMIT=3:
  - Three consecutive errors set fault=1 and locked=0 after sample 20.
  - A following sample 21 leaves sample_count=4 and err_count=3.
  - clear then returns all outputs to 0 and the state to UNLOCKED.
- Reset mid-stream: after 0..4, assert rst for 1 cycle, then send 100:
  - No seq_err.
  - locked=1, sample_count=1, above_thresh=1.
- Saturation: force 300 mismatches with ERR_LIMIT=15, interleaving correct samples so FAULT is never reached → err_count holds at 255.
